rv_dmem_resp: RTL and testbench
===============================

Name: rv_dmem_resp

Overview:
- Data-memory responder serving the multicycle RISC-V core's load/store requests; sits between the datapath's dmem port and on-chip storage.
- Single-outstanding request/ready handshake; parameterised wait states, byte-enable writes, error reporting for misaligned and out-of-range addresses.
- Adds stall-capable memory timing so control logic can be exercised against non-zero-latency memory.

Parameters:
- DPWIDTH, 32, data/address width; fixed at 32, four byte lanes.
- DEPTH, 1024, storage size in 32-bit words; power of two.
- LATENCY, 2, wait cycles between acceptance and response; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; captured with req.
- addr  input  DPWIDTH  byte address; captured with req.
- wdata  input  DPWIDTH  store data; captured with req.
- be  input  4  byte enables for stores, bit i = byte lane i; ignored for loads.
- rdata  output  DPWIDTH  load data; registered.
- ready  output  1  one-cycle response strobe; registered.
- err  output  1  error flag, valid only with ready; registered.

Behaviour:
- Interface fixed: one clock (clk); asynchronous active-low reset (rst).
- Reset values: state=IDLE, ready=0, err=0, rdata=0, wait counter=0. Storage array is not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req=1 captures we/addr/wdata/be into holding registers.
  - Loads counter with LATENCY-1 and moves to BUSY.
  - req=0 stays in IDLE.
- BUSY:
  - Counter decrements each cycle.
  - At counter==0, the access is performed on that edge and the FSM moves to RESP.
  - req is ignored while in BUSY.
- RESP:
  - ready=1 for exactly this cycle; next state is always IDLE.
  - req is ignored in RESP (one dead cycle between transactions).
- Latency: req sampled high in cycle 0 gives ready=1 in cycle LATENCY+1. Max throughput is one transaction per LATENCY+2 cycles.
- Address decode:
  - Word index = addr[log2(DEPTH)+1:2].
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr >= DEPTH*4.
- Error handling: misaligned or out-of-range gives err=1 with ready; no storage write; rdata holds its previous value.
- Load: rdata = storage[index], latched on the BUSY→RESP edge, then held until the next successful load.
- Store:
  - Byte lane i written only when be[i]=1; other lanes keep old contents.
  - be=0000 is legal; it completes with ready=1, err=0 and writes nothing.
  - A store leaves rdata unchanged.
- Read-after-write: a load issued after a store's ready returns the updated data.
- Reset mid-operation: a pending access is discarded (no write), FSM returns to IDLE, outputs go to reset values, storage contents are retained.
- A req held high across RESP starts a new transaction in the following IDLE cycle.

Decomposition:
- Shared package rv_mem_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - byte-lane count constant (4)
  - LATENCY bounds constants (1, 15)
  - error-type constants (ERR_NONE, ERR_MISALIGN, ERR_RANGE), kept for future status reporting
- Sub-module rv_dmem_array:
  - DEPTH x 32 storage with per-lane write enables.
  - Synchronous read port, single clock.
  - No reset.
- rv_dmem_resp holds the FSM, counter, holding registers, address checks and output registers.

Test Plan:
- Reset with LATENCY=2; store addr=0x10, wdata=0xDEADBEEF, be=1111 in cycle 0 → ready=1, err=0 in cycle 3; rdata remains 0.
- Load addr=0x10 after that store → ready in cycle 3, rdata=0xDEADBEEF, err=0.
- Store addr=0x10, wdata=0x000000AA, be=0001, then load 0x10 → rdata=0xDEADBEAA.
- Load addr=0x12 (misaligned) and load addr=0x1000 with DEPTH=1024 (out of range) → ready=1, err=1, rdata unchanged, no storage change.
- Hold req=1 continuously with LATENCY=1 → ready pulses every 3 cycles, each exactly 1 cycle wide.
- Drive rst=0 during BUSY of a store to addr 0x20 (previous contents 0x11111111) → ready/err/rdata=0, state IDLE; a later load of 0x20 returns 0x11111111.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LAT_MIN   = 1;
  localparam int unsigned LAT_MAX   = 15;

  // Error classes; only "not ERR_NONE" reaches the err pin today.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

// File: rtl/rv_dmem_array.sv
// Word-wide storage with per-byte-lane write enables and a registered read port.
module rv_dmem_array
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [NUM_LANES-1:0] we,
  input  logic [AW-1:0]        waddr,
  input  logic [31:0]          wdata,
  input  logic [AW-1:0]        raddr,
  output logic [31:0]          rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rd_data <= mem[raddr];
  end

endmodule

// File: rtl/rv_dmem_resp.sv
// Single-outstanding data-memory responder: fixed wait states, byte-lane stores,
// misaligned / out-of-range error reporting.
module rv_dmem_resp
  import rv_mem_pkg::*;
#(
  parameter int unsigned DPWIDTH = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [DPWIDTH-1:0]   addr,
  input  logic [DPWIDTH-1:0]   wdata,
  input  logic [NUM_LANES-1:0] be,
  output logic [DPWIDTH-1:0]   rdata,
  output logic                 ready,
  output logic                 err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LAT_EFF = (LATENCY < LAT_MIN) ? LAT_MIN :
                                    (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam logic [3:0]  CNT_INIT = 4'(LAT_EFF - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [DPWIDTH-1:0]   addr_q, addr_d;
  logic [DPWIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_LANES-1:0] be_q, be_d;
  logic [DPWIDTH-1:0]   rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;

  logic [1:0]           err_code;
  logic [AW-1:0]        rd_idx;
  logic [NUM_LANES-1:0] mem_we;
  logic [31:0]          arr_rdata;

  always_comb begin
    if (addr_q[1:0] != 2'b00) begin
      err_code = ERR_MISALIGN;
    end else if (addr_q[DPWIDTH-1:AW+2] != '0) begin
      err_code = ERR_RANGE;
    end else begin
      err_code = ERR_NONE;
    end
  end

  // The array is read every cycle; steering the read index to the live address
  // in IDLE makes the word available by the last BUSY cycle even at LATENCY=1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = '0;
    rd_idx  = (state_q == IDLE) ? addr[AW+1:2] : addr_q[AW+1:2];

    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = (err_code != ERR_NONE);
          if (err_code == ERR_NONE) begin
            if (we_q) begin
              mem_we = be_q;
            end else begin
              rdata_d = arr_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  rv_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (addr_q[AW+1:2]),
    .wdata   (wdata_q),
    .raddr   (rd_idx),
    .rd_data (arr_rdata)
  );

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Bench for rv_dmem_resp: transaction-level reference model plus directed literal checks.
module tb_rv_dmem_resp;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  logic        req1 = 1'b0;
  logic [31:0] rdata1;
  logic        ready1;
  logic        err1;

  always #5 clk = ~clk;

  rv_dmem_resp #(
    .DPWIDTH (32),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .be    (be),
    .rdata (rdata),
    .ready (ready),
    .err   (err)
  );

  rv_dmem_resp #(
    .DPWIDTH (32),
    .DEPTH   (DEPTH),
    .LATENCY (1)
  ) dut1 (
    .clk   (clk),
    .rst   (rst),
    .req   (req1),
    .we    (1'b0),
    .addr  (32'h0),
    .wdata (32'h0),
    .be    (4'h0),
    .rdata (rdata1),
    .ready (ready1),
    .err   (err1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          resp_cnt = 0;
  int          t1_start = 0;
  bit          t1_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Reference: a response is due exactly LAT+1 cycles after the request cycle;
  // its effect is applied to the model memory when it is due.
  txn_t        t;
  bit          due_now;
  bit          exp_err;
  int unsigned idx;
  bit          e1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ready", ready, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
    end else begin
      due_now = (q.size() > 0) && (q[0].due == cyc);
      exp_err = 1'b0;
      if (due_now) begin
        t = q.pop_front();
        exp_err = (t.addr[1:0] != 2'b00) || (t.addr >= DEPTH * 4);
        if (!exp_err) begin
          idx = (t.addr >> 2) % DEPTH;
          if (t.we) begin
            for (int l = 0; l < 4; l++) begin
              if (t.be[l]) mem_m[idx][8*l +: 8] = t.wdata[8*l +: 8];
            end
          end else begin
            exp_rdata = mem_m[idx];
          end
        end
      end
      chk("ready", ready, due_now);
      if (due_now) chk("err", err, exp_err);
      chk("rdata", rdata, exp_rdata);
      if (ready) begin
        last_rdata = rdata;
        last_err   = err;
        resp_cnt++;
      end
      if (t1_on) begin
        e1 = (cyc >= t1_start + 2) && (((cyc - t1_start - 2) % 3) == 0);
        chk("ready1_pulse", ready1, e1);
        if (e1) chk("err1", err1, 0);
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  // While the responder is busy, req and the other inputs carry random junk.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    q.push_back('{due: cyc + LAT + 1, we: w, addr: a, wdata: d, be: b});
    repeat (LAT + 1) begin
      @(posedge clk);
      #1;
      req   = 1'($urandom);
      we    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      be    = 4'($urandom);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  int          rc;
  int unsigned r;
  logic [31:0] a;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_rdata", rdata, 0);
    chk("reset_ready", ready, 0);

    req1 = 1'b1;
    t1_start = cyc;
    t1_on = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    t1_on = 1'b0;
    req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int w = 0; w < 16; w++) begin
      issue(1'b1, 32'(w * 4), (w == 8) ? 32'h11111111 : $urandom, 4'hF);
    end
    chk("init_rdata_held", rdata, 0);

    rc = resp_cnt;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("st_seen", resp_cnt, rc + 1);
    chk("st_err", last_err, 0);
    chk("st_rdata_zero", rdata, 0);

    issue(1'b0, 32'h10, 32'h0, 4'h0);
    chk("ld_seen", resp_cnt, rc + 2);
    chk("ld_data", last_rdata, 32'hDEADBEEF);
    chk("ld_err", last_err, 0);

    issue(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    chk("partial_store", last_rdata, 32'hDEADBEAA);

    issue(1'b0, 32'h12, 32'h0, 4'h0);
    chk("misalign_err", last_err, 1);
    chk("misalign_rdata", last_rdata, 32'hDEADBEAA);
    issue(1'b0, 32'h1000, 32'h0, 4'h0);
    chk("range_err", last_err, 1);
    chk("range_rdata", last_rdata, 32'hDEADBEAA);
    issue(1'b1, 32'h12, 32'h55555555, 4'hF);
    issue(1'b1, 32'h1010, 32'h66666666, 4'hF);
    issue(1'b1, 32'h10, 32'h77777777, 4'h0);
    chk("be0_err", last_err, 0);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    chk("no_err_write", last_rdata, 32'hDEADBEAA);

    // Reset asserted while a store to 0x20 is still waiting.
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'hCAFEF00D;
    be    = 4'hF;
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b0;
    q.delete();
    exp_rdata = '0;
    #1;
    chk("midrst_rdata", rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rc = resp_cnt;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    chk("midrst_seen", resp_cnt, rc + 1);
    chk("midrst_kept", last_rdata, 32'h11111111);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(9, 0);
      if (r < 8) begin
        a = 32'($urandom_range(15, 0)) << 2;
      end else if (r == 8) begin
        a = (32'($urandom_range(15, 0)) << 2) | 32'($urandom_range(3, 1));
      end else begin
        a = $urandom | 32'h1000;
      end
      issue(1'($urandom), a, $urandom, 4'($urandom));
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
